// File: rtl/rgb_mode_select.sv
// Per-pixel RGB channel selector: passthrough, single channel, luma, dark mask or inverted luma.
// Define RGBSEL_DARKCNT_EN to build the per-frame dark-pixel counter.
module rgb_mode_select #(
   parameter int DW = 10,
   parameter int CW = 20
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iFVAL,
   input  logic          iDVAL,
   input  logic [DW-1:0] iRed,
   input  logic [DW-1:0] iGreen,
   input  logic [DW-1:0] iBlue,
   input  logic [2:0]    iMODE,
   input  logic [DW-1:0] iTHRESH,
   output logic          oDVAL,
   output logic [DW-1:0] oDATA_R,
   output logic [DW-1:0] oDATA_G,
   output logic [DW-1:0] oDATA_B,
   output logic [CW-1:0] oDARK_CNT,
   output logic          oCNT_VALID
);

   typedef enum logic [2:0] {
      MODE_PASS  = 3'd0,
      MODE_RED   = 3'd1,
      MODE_GREEN = 3'd2,
      MODE_BLUE  = 3'd3,
      MODE_GRAY  = 3'd4,
      MODE_MASK  = 3'd5,
      MODE_INV   = 3'd6,
      MODE_BLANK = 3'd7
   } mode_t;

   logic          fval_d;
   mode_t         mode_q;
   logic [DW-1:0] thr_q;

   logic          rise;
   logic          accepted;
   mode_t         eff_mode;
   logic [DW-1:0] eff_thr;
   logic [DW+1:0] sum;
   logic [DW-1:0] gray;
   logic          dark;

   logic          v1;
   mode_t         mode1;
   logic [DW-1:0] r1, g1, b1, gray1;
   logic          dark1;

   logic [DW-1:0] mux_r, mux_g, mux_b;

   // Pixels in the rise cycle already see the new mode/threshold.
   assign rise     = iFVAL & ~fval_d;
   assign accepted = iDVAL & iFVAL;
   assign eff_mode = rise ? mode_t'(iMODE) : mode_q;
   assign eff_thr  = rise ? iTHRESH : thr_q;
   assign sum      = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
   assign gray     = sum[DW+1:2];
   assign dark     = (gray < eff_thr);

   // Frame-edge tracking, frame-start sampling and stage 1.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         fval_d <= 1'b0;
         mode_q <= MODE_PASS;
         thr_q  <= '0;
         v1     <= 1'b0;
         mode1  <= MODE_PASS;
         r1     <= '0;
         g1     <= '0;
         b1     <= '0;
         gray1  <= '0;
         dark1  <= 1'b0;
      end else begin
         fval_d <= iFVAL;
         if (rise) begin
            mode_q <= mode_t'(iMODE);
            thr_q  <= iTHRESH;
         end
         v1 <= accepted;
         if (accepted) begin
            mode1 <= eff_mode;
            r1    <= iRed;
            g1    <= iGreen;
            b1    <= iBlue;
            gray1 <= gray;
            dark1 <= dark;
         end
      end
   end

   // Stage 2 mode mux.
   always_comb begin
      mux_r = '0;
      mux_g = '0;
      mux_b = '0;
      case (mode1)
         MODE_PASS: begin
            mux_r = r1;
            mux_g = g1;
            mux_b = b1;
         end
         MODE_RED:   mux_r = r1;
         MODE_GREEN: mux_g = g1;
         MODE_BLUE:  mux_b = b1;
         MODE_GRAY: begin
            mux_r = gray1;
            mux_g = gray1;
            mux_b = gray1;
         end
         MODE_MASK: begin
            mux_r = {DW{dark1}};
            mux_g = {DW{dark1}};
            mux_b = {DW{dark1}};
         end
         MODE_INV: begin
            mux_r = ~gray1;
            mux_g = ~gray1;
            mux_b = ~gray1;
         end
         MODE_BLANK: begin
            mux_r = '0;
            mux_g = '0;
            mux_b = '0;
         end
         default: begin
            mux_r = '0;
            mux_g = '0;
            mux_b = '0;
         end
      endcase
   end

   // Stage 2 output registers.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oDVAL   <= 1'b0;
         oDATA_R <= '0;
         oDATA_G <= '0;
         oDATA_B <= '0;
      end else begin
         oDVAL <= v1;
         if (v1) begin
            oDATA_R <= mux_r;
            oDATA_G <= mux_g;
            oDATA_B <= mux_b;
         end
      end
   end

`ifdef RGBSEL_DARKCNT_EN
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic          fall;
   logic [CW-1:0] cnt;

   assign fall = ~iFVAL & fval_d;

   // Saturating dark counter; a fall never coincides with a rise, so the capture precedes the clear.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         cnt        <= '0;
         oDARK_CNT  <= '0;
         oCNT_VALID <= 1'b0;
      end else begin
         if (rise) begin
            cnt <= (accepted & dark) ? CNT_ONE : '0;
         end else if (accepted & dark & (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
         end
         oCNT_VALID <= fall;
         if (fall) begin
            oDARK_CNT <= cnt;
         end
      end
   end
`else
   assign oDARK_CNT  = '0;
   assign oCNT_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_mode_select.sv
// Directed testbench for rgb_mode_select (DW=10, CW=3); counter checks follow RGBSEL_DARKCNT_EN.
module tb_rgb_mode_select;
   localparam int DW = 10;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fval = 1'b0;
   logic          dval = 1'b0;
   logic [DW-1:0] red = '0, green = '0, blue = '0;
   logic [2:0]    mode = 3'd0;
   logic [DW-1:0] thresh = '0;
   logic          odval;
   logic [DW-1:0] odr, odg, odb;
   logic [CW-1:0] dark_cnt;
   logic          cnt_valid;

   int errors = 0;
   int checks = 0;

   logic [3*DW-1:0] out_q[$];
   logic [CW-1:0]   cnt_hist[$];
   int              stray = 0;

   logic [DW-1:0] pr[16];
   logic [DW-1:0] pg[16];
   logic [DW-1:0] pb[16];

   always #5 clk = ~clk;

   rgb_mode_select #(.DW(DW), .CW(CW)) dut (
      .iCLK(clk), .iRST(rst), .iFVAL(fval), .iDVAL(dval),
      .iRed(red), .iGreen(green), .iBlue(blue),
      .iMODE(mode), .iTHRESH(thresh),
      .oDVAL(odval), .oDATA_R(odr), .oDATA_G(odg), .oDATA_B(odb),
      .oDARK_CNT(dark_cnt), .oCNT_VALID(cnt_valid)
   );

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (odval === 1'b1) out_q.push_back({odr, odg, odb});
      if (cnt_valid === 1'b1) cnt_hist.push_back(dark_cnt);
      if (cnt_valid !== 1'b0 || dark_cnt !== '0) stray++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_px(input string tag, input int idx,
                         input logic [DW-1:0] er, input logic [DW-1:0] eg, input logic [DW-1:0] eb);
      logic [3*DW-1:0] v;
      v = 'x;
      if (idx < out_q.size()) v = out_q[idx];
      chk({tag, "_r"}, 32'(v[3*DW-1:2*DW]), 32'(er));
      chk({tag, "_g"}, 32'(v[2*DW-1:DW]), 32'(eg));
      chk({tag, "_b"}, 32'(v[DW-1:0]), 32'(eb));
   endtask

   // Threshold is only presented on the first pixel; later pixels drive 0 to prove it is held.
   task automatic send_frame(input int n, input logic [2:0] m, input logic [2:0] m2, input int sw,
                             input logic [DW-1:0] thr, input int gap);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         fval   = 1'b1;
         dval   = 1'b1;
         mode   = (i >= sw) ? m2 : m;
         thresh = (i == 0) ? thr : 10'd0;
         red    = pr[i];
         green  = pg[i];
         blue   = pb[i];
      end
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         fval = 1'b0;
         dval = 1'b0;
      end
   endtask

   task automatic set_px(input int i, input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b);
      pr[i] = r;
      pg[i] = g;
      pb[i] = b;
   endtask

   initial begin
      int ob;
      int pbase;
      logic [9:0] pattern;

      // Reset with a live frame on the inputs.
      rst = 1'b1; fval = 1'b1; dval = 1'b1;
      red = 10'h3FF; green = 10'h3FF; blue = 10'h3FF; mode = 3'd0; thresh = 10'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_dval", 32'(odval), 32'd0);
      chk("rst_r", 32'(odr), 32'd0);
      chk("rst_g", 32'(odg), 32'd0);
      chk("rst_b", 32'(odb), 32'd0);
      chk("rst_cnt", 32'(dark_cnt), 32'd0);
      chk("rst_cvalid", 32'(cnt_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("lat1_dval", 32'(odval), 32'd0);
      @(negedge clk); #1;
      chk("lat2_dval", 32'(odval), 32'd1);
      chk("lat2_r", 32'(odr), 32'h3FF);
      chk("lat2_g", 32'(odg), 32'h3FF);
      chk("lat2_b", 32'(odb), 32'h3FF);
      fval = 1'b0; dval = 1'b0;
      repeat (4) @(negedge clk);

      // Luma and inverted luma.
      set_px(0, 10'd100, 10'd200, 10'd300);
      ob = out_q.size();
      send_frame(1, 3'd4, 3'd4, 99, 10'd0, 4);
      send_frame(1, 3'd6, 3'd6, 99, 10'd0, 4);
      #1;
      chk("gray_n", 32'(out_q.size() - ob), 32'd2);
      chk_px("gray", ob, 10'd200, 10'd200, 10'd200);
      chk_px("inv", ob + 1, 10'd823, 10'd823, 10'd823);

      // Mode switched mid-frame is ignored; next frame uses it.
      for (int i = 0; i < 4; i++) set_px(i, 10'(10 + i), 10'(20 + i), 10'(30 + i));
      ob = out_q.size();
      send_frame(4, 3'd3, 3'd1, 2, 10'd0, 1);
      send_frame(4, 3'd1, 3'd1, 99, 10'd0, 4);
      #1;
      chk("sw_n", 32'(out_q.size() - ob), 32'd8);
      for (int i = 0; i < 4; i++) chk_px("sw_blue", ob + i, 10'd0, 10'd0, 10'(30 + i));
      for (int i = 0; i < 4; i++) chk_px("sw_red", ob + 4 + i, 10'(10 + i), 10'd0, 10'd0);

      // Dark mask, threshold 128: four pixels with gray 50, six with gray 200.
      pattern = 10'b1000100101;
      for (int i = 0; i < 10; i++) begin
         if (pattern[i]) set_px(i, 10'd50, 10'd50, 10'd50);
         else set_px(i, 10'd200, 10'd200, 10'd200);
      end
      ob = out_q.size();
      pbase = cnt_hist.size();
      send_frame(10, 3'd5, 3'd5, 99, 10'd128, 4);
      #1;
      chk("mask_n", 32'(out_q.size() - ob), 32'd10);
      for (int i = 0; i < 10; i++) begin
         if (pattern[i]) chk_px("mask_dark", ob + i, 10'h3FF, 10'h3FF, 10'h3FF);
         else chk_px("mask_light", ob + i, 10'd0, 10'd0, 10'd0);
      end
`ifdef RGBSEL_DARKCNT_EN
      chk("mask_pulses", 32'(cnt_hist.size() - pbase), 32'd1);
      if (cnt_hist.size() > pbase) chk("mask_cnt", 32'(cnt_hist[pbase]), 32'd4);
      else chk("mask_cnt", 32'hFFFF_FFFF, 32'd4);
`else
      chk("mask_pulses", 32'(cnt_hist.size() - pbase), 32'd0);
`endif

      // Saturation, then back-to-back frame with a one-cycle gap.
      for (int i = 0; i < 12; i++) set_px(i, 10'd50, 10'd50, 10'd50);
      pbase = cnt_hist.size();
      send_frame(12, 3'd5, 3'd5, 99, 10'd128, 1);
      send_frame(2, 3'd5, 3'd5, 99, 10'd128, 4);
      #1;
`ifdef RGBSEL_DARKCNT_EN
      chk("sat_pulses", 32'(cnt_hist.size() - pbase), 32'd2);
      if (cnt_hist.size() >= pbase + 2) begin
         chk("sat_cnt", 32'(cnt_hist[pbase]), 32'd7);
         chk("b2b_cnt", 32'(cnt_hist[pbase + 1]), 32'd2);
      end else begin
         chk("sat_cnt_missing", 32'(cnt_hist.size()), 32'(pbase + 2));
      end
`else
      chk("sat_pulses", 32'(cnt_hist.size() - pbase), 32'd0);
`endif

      // Pixel valid without frame valid is dropped.
      ob = out_q.size();
      pbase = cnt_hist.size();
      @(negedge clk);
      fval = 1'b0; dval = 1'b1;
      red = 10'd50; green = 10'd50; blue = 10'd50;
      repeat (3) @(negedge clk);
      dval = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("orphan_n", 32'(out_q.size() - ob), 32'd0);
      chk("orphan_pulses", 32'(cnt_hist.size() - pbase), 32'd0);
`ifdef RGBSEL_DARKCNT_EN
      chk("orphan_cnt", 32'(dark_cnt), 32'd2);
`else
      chk("tied_cnt", 32'(stray), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
